// File: rtl/cache_fill_engine.sv
// Cache block-fill controller: one read request per cycle per block word, in-order responses written to the data array, then a tag write. CACHE_FILL_CRIT_WORD_FIRST_EN enables critical-word-first ordering and crit_ready.
// Latency: first request the cycle after the miss; the tag write follows the last response by one cycle; busy is combinational in the miss cycle.
// Backpressure: none accepted from memory; busy stalls the pipeline from the miss cycle through DONE.
module cache_fill_engine #(
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 16,
    parameter int WORDS_PER_BLOCK = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic [DATA_W-1:0] mem_data_in,
    input  logic              mem_data_valid,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              busy,
    output logic              data_we,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_out,
    output logic              tag_we,
    output logic [ADDR_W-1:0] tag_addr,
    output logic              crit_ready
);
    localparam int BYTES_PER_WORD = DATA_W / 8;
    localparam int BSH            = $clog2(BYTES_PER_WORD);
    localparam int OFF_W          = $clog2(WORDS_PER_BLOCK * BYTES_PER_WORD);
    localparam int IDX_W          = $clog2(WORDS_PER_BLOCK);
    localparam int CNT_W          = IDX_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [IDX_W-1:0]  start_q, start_d;
    logic [CNT_W-1:0]  issue_q, issue_d;
    logic [CNT_W-1:0]  recv_q, recv_d;
    logic [IDX_W-1:0]  miss_idx;
    logic [IDX_W-1:0]  issue_idx;
    logic [IDX_W-1:0]  recv_idx;
    logic              in_fill;
    logic              req_now;
    logic              wr_now;

`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
    logic crit_q, crit_d;
    assign miss_idx   = miss_address[OFF_W-1:BSH];
    assign crit_d     = wr_now && (recv_q == '0);
    assign crit_ready = crit_q;
`else
    assign miss_idx   = '0;
    assign crit_ready = 1'b0;
`endif

    assign in_fill   = (state_q == FILL);
    assign req_now   = in_fill && (issue_q < CNT_W'(WORDS_PER_BLOCK));
    assign wr_now    = in_fill && mem_data_valid;
    // Index arithmetic is IDX_W wide, so the wrap modulo block size is free.
    assign issue_idx = start_q + issue_q[IDX_W-1:0];
    assign recv_idx  = start_q + recv_q[IDX_W-1:0];

    assign mem_req   = req_now;
    assign mem_addr  = req_now ? base_q + (ADDR_W'(issue_idx) << BSH) : '0;
    assign data_we   = wr_now;
    assign data_addr = wr_now ? base_q + (ADDR_W'(recv_idx) << BSH) : '0;
    assign data_out  = wr_now ? mem_data_in : '0;
    assign tag_we    = (state_q == DONE);
    assign tag_addr  = (state_q != IDLE) ? base_q : '0;
    assign busy      = !rst && ((state_q != IDLE) || miss_detected);

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        start_d = start_q;
        issue_d = issue_q;
        recv_d  = recv_q;
        case (state_q)
            IDLE: begin
                if (miss_detected) begin
                    base_d  = {miss_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    start_d = miss_idx;
                    issue_d = '0;
                    recv_d  = '0;
                    state_d = FILL;
                end
            end
            FILL: begin
                if (req_now) begin
                    issue_d = issue_q + CNT_W'(1);
                end
                if (mem_data_valid) begin
                    recv_d = recv_q + CNT_W'(1);
                    if (recv_q == CNT_W'(WORDS_PER_BLOCK - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            start_q <= '0;
            issue_q <= '0;
            recv_q  <= '0;
`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
            crit_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            start_q <= start_d;
            issue_q <= issue_d;
            recv_q  <= recv_d;
`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
            crit_q  <= crit_d;
`endif
        end
    end
endmodule

// File: tb/tb_cache_fill_engine.sv
// Bench for cache_fill_engine: a default 16-bit/8-word instance and a 32-bit/4-word instance, selected by sel.
module tb_cache_fill_engine;
`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
    localparam bit CRIT_EN = 1'b1;
`else
    localparam bit CRIT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        miss;
    logic        valid_drv;
    logic [15:0] miss_addr;
    logic [31:0] din;

    logic        r16, b16, we16, tw16, cr16;
    logic [15:0] ma16, da16, ta16, do16;
    logic        r32, b32, we32, tw32, cr32;
    logic [15:0] ma32, da32, ta32;
    logic [31:0] do32;

    logic        o_req, o_busy, o_we, o_tag, o_crit;
    logic [15:0] o_maddr, o_daddr, o_taddr;
    logic [31:0] o_dout;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cache_fill_engine dut16 (
        .clk(clk), .rst(rst),
        .miss_detected(miss & !sel), .miss_address(miss_addr),
        .mem_data_in(din[15:0]), .mem_data_valid(valid_drv & !sel),
        .mem_req(r16), .mem_addr(ma16), .busy(b16),
        .data_we(we16), .data_addr(da16), .data_out(do16),
        .tag_we(tw16), .tag_addr(ta16), .crit_ready(cr16)
    );

    cache_fill_engine #(.ADDR_W(16), .DATA_W(32), .WORDS_PER_BLOCK(4)) dut32 (
        .clk(clk), .rst(rst),
        .miss_detected(miss & sel), .miss_address(miss_addr),
        .mem_data_in(din), .mem_data_valid(valid_drv & sel),
        .mem_req(r32), .mem_addr(ma32), .busy(b32),
        .data_we(we32), .data_addr(da32), .data_out(do32),
        .tag_we(tw32), .tag_addr(ta32), .crit_ready(cr32)
    );

    assign o_req   = sel ? r32  : r16;
    assign o_busy  = sel ? b32  : b16;
    assign o_we    = sel ? we32 : we16;
    assign o_tag   = sel ? tw32 : tw16;
    assign o_crit  = sel ? cr32 : cr16;
    assign o_maddr = sel ? ma32 : ma16;
    assign o_daddr = sel ? da32 : da16;
    assign o_taddr = sel ? ta32 : ta16;
    assign o_dout  = sel ? do32 : {16'h0, do16};

    // One complete fill against the reference: block base, wrapped word order, one request per cycle,
    // one write per response, tag write the cycle after the last write, busy throughout.
    task automatic run_fill(input logic [15:0] a, input int lat, input int gap, input bit stray, input bit hold);
        int W, BPW, ai, base_i, start, c, writes, first_wr, last_wr, nreq;
        int pend[$];
        logic [15:0] base, exp_a, exp_ta;
        logic [31:0] d, exp_d;
        bit vin, exp_req, exp_we, exp_tag, exp_crit, done;
        W = sel ? 4 : 8;
        BPW = sel ? 4 : 2;
        ai = int'(a);
        base_i = ai - (ai % (W * BPW));
        base = 16'(base_i);
        start = CRIT_EN ? (ai % (W * BPW)) / BPW : 0;
        c = 0; writes = 0; first_wr = -1; last_wr = -1; nreq = 0; done = 0;
        while (!done) begin
            #1;
            miss = (c == 0) || hold;
            miss_addr = a;
            vin = 1'b0;
            if (c == 0 && stray) vin = 1'b1;
            else if (pend.size() > 0 && c >= pend[0] && (gap == 0 || c % gap == 0)) begin
                vin = 1'b1;
                void'(pend.pop_front());
            end
            d = $urandom;
            din = d;
            valid_drv = vin;
            @(negedge clk);
            exp_req  = (c >= 1) && (c <= W);
            exp_we   = vin && (c >= 1) && (writes < W);
            exp_tag  = (writes == W) && (c == last_wr + 1);
            exp_crit = CRIT_EN && (first_wr >= 0) && (c == first_wr + 1);
            exp_ta   = (c >= 1) ? base : 16'h0;
            tests++;
            if (o_busy !== 1'b1) begin fails++; $display("FAIL busy cyc=%0d got=%b exp=1", c, o_busy); end
            tests++;
            if (o_req !== exp_req) begin fails++; $display("FAIL mem_req cyc=%0d got=%b exp=%b", c, o_req, exp_req); end
            if (o_req === 1'b1) begin
                exp_a = 16'(base_i + ((start + nreq) % W) * BPW);
                tests++;
                if (o_maddr !== exp_a) begin fails++; $display("FAIL mem_addr cyc=%0d got=%h exp=%h", c, o_maddr, exp_a); end
                pend.push_back(c + lat);
                nreq++;
            end
            tests++;
            if (o_we !== exp_we) begin fails++; $display("FAIL data_we cyc=%0d got=%b exp=%b", c, o_we, exp_we); end
            if (exp_we) begin
                exp_a = 16'(base_i + ((start + writes) % W) * BPW);
                exp_d = sel ? d : {16'h0, d[15:0]};
                tests++;
                if (o_daddr !== exp_a || o_dout !== exp_d) begin
                    fails++;
                    $display("FAIL data_write cyc=%0d got=%h/%h exp=%h/%h", c, o_daddr, o_dout, exp_a, exp_d);
                end
                if (first_wr < 0) first_wr = c;
                last_wr = c;
                writes++;
            end
            tests++;
            if (o_tag !== exp_tag || o_taddr !== exp_ta) begin
                fails++;
                $display("FAIL tag cyc=%0d got=%b/%h exp=%b/%h", c, o_tag, o_taddr, exp_tag, exp_ta);
            end
            tests++;
            if (o_crit !== exp_crit) begin fails++; $display("FAIL crit_ready cyc=%0d got=%b exp=%b", c, o_crit, exp_crit); end
            if (exp_tag) done = 1'b1;
            c++;
            if (!done && c > 200) begin
                fails++;
                $display("FAIL fill_timeout addr=%h writes=%0d exp=%0d", a, writes, W);
                done = 1'b1;
            end
            @(posedge clk);
        end
        if (!hold) begin
            #1;
            miss = 1'b0;
            valid_drv = 1'b0;
            @(negedge clk);
            tests++;
            if (o_busy !== 1'b0 || o_tag !== 1'b0 || o_req !== 1'b0) begin
                fails++;
                $display("FAIL after_done busy/tag/req got=%b%b%b exp=000", o_busy, o_tag, o_req);
            end
            @(posedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; sel = 1'b0; miss = 1'b0; valid_drv = 1'b0; miss_addr = 16'h0; din = 32'h0;
        #2;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            tests++;
            if ({o_req, o_busy, o_we, o_tag, o_crit} !== 5'b0 || o_maddr !== 16'h0 || o_daddr !== 16'h0
                || o_taddr !== 16'h0 || o_dout !== 32'h0) begin
                fails++;
                $display("FAIL reset_outputs sel=%0d got=%b%b%b%b%b exp=00000", s, o_req, o_busy, o_we, o_tag, o_crit);
            end
        end
        sel = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_directed();
        sel = 1'b0;
        run_fill(16'h1236, 4, 0, 1'b0, 1'b0);
    endtask

    task automatic test_wide_block();
        sel = 1'b1;
        run_fill(16'h00F4, 4, 0, 1'b0, 1'b0);
        run_fill(16'h00FB, 1, 0, 1'b0, 1'b0);
        sel = 1'b0;
    endtask

    task automatic test_reset_mid_fill();
        sel = 1'b0;
        #1 miss = 1'b1; miss_addr = 16'h1236; valid_drv = 1'b0;
        @(posedge clk);
        for (int i = 1; i < 7; i++) begin
            #1 miss = 1'b0;
            @(posedge clk);
        end
        #1 rst = 1'b1;
        #1;
        tests++;
        if ({o_req, o_busy, o_we, o_tag, o_crit} !== 5'b0 || o_maddr !== 16'h0 || o_taddr !== 16'h0) begin
            fails++;
            $display("FAIL mid_fill_reset got=%b%b%b%b%b exp=00000", o_req, o_busy, o_we, o_tag, o_crit);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            valid_drv = (i % 2 == 0);
            din = $urandom;
            @(negedge clk);
            tests++;
            if (o_we !== 1'b0 || o_tag !== 1'b0 || o_busy !== 1'b0 || o_req !== 1'b0) begin
                fails++;
                $display("FAIL post_reset_ignore i=%0d we/tag/busy/req got=%b%b%b%b exp=0000", i, o_we, o_tag, o_busy, o_req);
            end
            @(posedge clk);
            #1;
        end
        valid_drv = 1'b0;
        @(posedge clk);
        run_fill(16'h0A5E, 2, 0, 1'b0, 1'b0);
    endtask

    task automatic test_stray_gap();
        sel = 1'b0;
        #1 valid_drv = 1'b1; din = 32'hDEAD_BEEF;
        @(negedge clk);
        tests++;
        if (o_we !== 1'b0 || o_busy !== 1'b0) begin
            fails++;
            $display("FAIL idle_stray we/busy got=%b%b exp=00", o_we, o_busy);
        end
        @(posedge clk);
        run_fill(16'h3418, 1, 3, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        sel = 1'b0;
        run_fill(16'h2000, 3, 0, 1'b0, 1'b1);
        run_fill(16'h2ABC, 2, 0, 1'b0, 1'b1);
        run_fill(16'hFFFE, 4, 0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        int g;
        for (int i = 0; i < 12; i++) begin
            sel = $urandom_range(0, 1);
            g = $urandom_range(0, 2);
            run_fill(16'($urandom), $urandom_range(1, 6), (g == 0) ? 0 : g + 1, 1'($urandom_range(0, 1)), 1'b0);
        end
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_wide_block();
        test_reset_mid_fill();
        test_stray_gap();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cache_fill_engine.md
Name: cache_fill_engine

Overview:
Parametrised cache block-fill controller that replaces the fixed 16-bit, 8-word fill FSM. On a miss it issues one pipelined memory read per cycle for every word of the missing block and accepts in-order responses. It writes each returned word into the cache data array, then pulses the tag write. It sits between the cache tag-match logic and the memory model, and its busy output stalls the pipeline.

Parameters:
ADDR_W, 16, byte-address width.
DATA_W, 16, word width in bits; must be a multiple of 8, power of two.
WORDS_PER_BLOCK, 8, words per cache block; power of two, >= 2.
Derived (localparam): BYTES_PER_WORD = DATA_W/8; OFF_W = log2(WORDS_PER_BLOCK*BYTES_PER_WORD); IDX_W = log2(WORDS_PER_BLOCK).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
miss_detected  in  1  tag-match miss, level; sampled only in IDLE.
miss_address  in  ADDR_W  byte address that missed.
mem_data_in  in  DATA_W  read data returned by memory.
mem_data_valid  in  1  mem_data_in valid this cycle; responses in request order.
mem_req  out  1  read request this cycle.
mem_addr  out  ADDR_W  read byte address, word-aligned.
busy  out  1  stall: fill in progress.
data_we  out  1  data-array write enable.
data_addr  out  ADDR_W  data-array byte address for data_out.
data_out  out  DATA_W  word to write (= mem_data_in).
tag_we  out  1  tag-array write enable, one-cycle pulse.
tag_addr  out  ADDR_W  block base address being filled.
crit_ready  out  1  missed word now in array (early restart).

Behaviour:
- States: IDLE, FILL, DONE. Reset (async) -> IDLE; all counters 0, base 0; every output 0.
- IDLE: miss_detected=1 -> latch base = miss_address with low OFF_W bits cleared, and latch the start index. Clear issue_cnt and recv_cnt. Next state FILL. busy = 1 combinationally in the miss cycle (busy = state!=IDLE | (IDLE & miss_detected)).
- FILL:
  - mem_req=1 while issue_cnt < WORDS_PER_BLOCK.
  - mem_addr = base + ((start+issue_cnt) mod WORDS_PER_BLOCK)*BYTES_PER_WORD.
  - issue_cnt increments each requesting cycle.
- On mem_data_valid in FILL, same cycle:
  - data_we=1 and data_out=mem_data_in.
  - data_addr = base + ((start+recv_cnt) mod WORDS_PER_BLOCK)*BYTES_PER_WORD.
  - recv_cnt increments.
- Last word (recv_cnt = WORDS_PER_BLOCK-1 with valid) -> DONE.
- DONE: tag_we=1, tag_addr=base for exactly one cycle, busy=1; next IDLE. busy falls in the cycle after DONE.
- tag_addr = base whenever state != IDLE, else 0.
- Offset arithmetic wraps modulo block size; base is never modified. Counters are IDX_W+1 bits.
- mem_data_valid in IDLE or DONE: ignored, no write.
- miss_detected in FILL/DONE: ignored; a new miss is accepted only from IDLE (earliest the cycle after DONE).
- Issue phase and responses overlap; valid arriving while mem_req is still high is legal.
- rst mid-fill: immediate IDLE, no tag_we, outstanding responses ignored.
- Without the optional feature: start=0, crit_ready=0.

Optional Feature:
CACHE_FILL_CRIT_WORD_FIRST_EN
- Defined: start = miss_address[OFF_W-1:log2(BYTES_PER_WORD)]. Requests and writes begin at the missed word and wrap through the block. crit_ready pulses for 1 cycle, one cycle after the first data_we (critical word written). busy is unchanged: still high until DONE completes.
- Not defined: start=0, fills in ascending order, crit_ready tied 0.

Test Plan:
- Defaults, memory returns each request 4 cycles later; miss at 0x1236 in cycle 0 -> mem_req cycles 1-8 with addresses 0x1230,0x1232,...,0x123E. data_we cycles 5-12 at the same addresses. tag_we=1, tag_addr=0x1230 in cycle 13. busy cycles 0-13, low in cycle 14.
- Same stimulus with CACHE_FILL_CRIT_WORD_FIRST_EN -> request order 0x1236,0x1238,0x123A,0x123C,0x123E,0x1230,0x1232,0x1234. crit_ready=1 in cycle 6 only. tag_we in cycle 13.
- Assert rst in cycle 7 of a fill -> all outputs 0 immediately. Later mem_data_valid pulses produce no data_we and no tag_we. A new miss after rst deasserts fills normally.
- Hold miss_detected=1 continuously -> second fill starts the cycle after DONE. No overlap; exactly one tag_we per fill.
- DATA_W=32, WORDS_PER_BLOCK=4, ADDR_W=16; miss at 0x00F4 -> addresses 0x00F0,0x00F4,0x00F8,0x00FC; tag_addr=0x00F0.
- Stray mem_data_valid in IDLE and an irregular response gap (valid every 3rd cycle) -> no write in IDLE; all 8 words written in order; tag_we one cycle after the 8th.
